add_pipe: RTL

//   Parametrised, pipelined successor to the combinational 16-bit adder/incrementer.

---
 rtl/add_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/add_pipe.sv
// Pipelined adder/incrementer: a WIDTH-bit add split into STAGES chunks, one chunk
// per clock, with the carry rippling stage to stage under a global-stall handshake.
module add_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] bp_in;
    logic             cin_in;
    logic             ovf_q;

    // Operand prep: every mode reduces to a + b' + cin
    always_comb begin
        bp_in  = '0;
        cin_in = 1'b0;
        case (mode)
            2'b00:   bp_in = b;
            2'b01:   cin_in = 1'b1;
            2'b10: begin
                bp_in  = ~b;
                cin_in = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage k: w carries a with chunks 0..k-1 already replaced by sum bits;
    // bp only keeps the b' chunks that have not been consumed yet.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RB = WIDTH - k * CW;

        logic [WIDTH-1:0] w_src;
        logic [WIDTH-1:0] w_nxt;
        logic [WIDTH-1:0] w_q;
        logic [RB-1:0]    bp_src;
        logic             c_src;
        logic             v_src;
        logic             c_q;
        logic             v_q;
        logic [CW:0]      part;

        if (k == 0) begin : g_entry
            assign w_src  = a;
            assign bp_src = bp_in;
            assign c_src  = cin_in;
            assign v_src  = in_valid;
        end else begin : g_link
            assign w_src  = g_stage[k-1].w_q;
            assign bp_src = g_stage[k-1].g_mid.bp_q;
            assign c_src  = g_stage[k-1].c_q;
            assign v_src  = g_stage[k-1].v_q;
        end

        always_comb begin
            part = {1'b0, w_src[k*CW +: CW]} + {1'b0, bp_src[CW-1:0]} + {{CW{1'b0}}, c_src};
            w_nxt = w_src;
            w_nxt[k*CW +: CW] = part[CW-1:0];
        end

        always_ff @(posedge clock) begin
            if (reset)
                v_q <= 1'b0;
            else if (advance)
                v_q <= v_src;
        end

        if (k < STAGES - 1) begin : g_mid
            logic [RB-CW-1:0] bp_q;

            always_ff @(posedge clock) begin
                if (advance) begin
                    w_q  <= w_nxt;
                    bp_q <= bp_src[RB-1:CW];
                    c_q  <= part[CW];
                end
            end
        end else begin : g_last
            // Output stage: only real results load, so bubbles leave the last value visible
            always_ff @(posedge clock) begin
                if (reset) begin
                    w_q   <= '0;
                    c_q   <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (advance && v_src) begin
                    w_q   <= w_nxt;
                    c_q   <= part[CW];
                    ovf_q <= (w_src[WIDTH-1] == bp_src[CW-1]) && (part[CW-1] != w_src[WIDTH-1]);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign sum       = g_stage[STAGES-1].w_q;
    assign carry     = g_stage[STAGES-1].c_q;
    assign overflow  = ovf_q;

endmodule
